// File: rtl/mm_job_arbiter.sv
// Shares one streaming 4x4 matrix-multiply engine between two AXI-Stream requesters,
// one whole job at a time, and pulses the engine reset between jobs.
module mm_job_arbiter #(
  parameter int pDATA_WIDTH = 32,
  parameter int pIN_WORDS   = 32,
  parameter int pOUT_WORDS  = 16,
  parameter int pRST_CYC    = 2
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s0_tvalid,
  input  logic [pDATA_WIDTH-1:0] s0_tdata,
  input  logic                   s0_tlast,
  output logic                   s0_tready,
  input  logic                   s1_tvalid,
  input  logic [pDATA_WIDTH-1:0] s1_tdata,
  input  logic                   s1_tlast,
  output logic                   s1_tready,
  output logic                   r0_tvalid,
  output logic [pDATA_WIDTH-1:0] r0_tdata,
  output logic                   r0_tlast,
  input  logic                   r0_tready,
  output logic                   r1_tvalid,
  output logic [pDATA_WIDTH-1:0] r1_tdata,
  output logic                   r1_tlast,
  input  logic                   r1_tready,
  output logic                   e_ss_tvalid,
  output logic [pDATA_WIDTH-1:0] e_ss_tdata,
  output logic                   e_ss_tlast,
  input  logic                   e_ss_tready,
  input  logic                   e_sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] e_sm_tdata,
  output logic                   e_sm_tready,
  output logic                   eng_rst_n,
  output logic                   owner,
  output logic                   busy,
  output logic                   err_tlast,
  output logic [15:0]            job_cnt0,
  output logic [15:0]            job_cnt1
);

  localparam int MAX_WORDS = (pIN_WORDS > pOUT_WORDS) ? pIN_WORDS : pOUT_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int RST_W     = $clog2(pRST_CYC) + 1;
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(pIN_WORDS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(pOUT_WORDS - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(pRST_CYC - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, ERST} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0] inCnt_q, inCnt_d;
  logic [CNT_W-1:0] outCnt_q, outCnt_d;
  logic [RST_W-1:0] rstCnt_q, rstCnt_d;
  logic             errTlast_q, errTlast_d;
  logic [15:0]      jobCnt0_q, jobCnt0_d;
  logic [15:0]      jobCnt1_q, jobCnt1_d;
  logic             engRstN_q, engRstN_d;

  logic                   selSValid;
  logic [pDATA_WIDTH-1:0] selSData;
  logic                   selSLast;
  logic                   selRReady;
  logic                   isInLast;
  logic                   isOutLast;
  logic                   inHs;
  logic                   outHs;

  assign selSValid = owner_q ? s1_tvalid : s0_tvalid;
  assign selSData  = owner_q ? s1_tdata  : s0_tdata;
  assign selSLast  = owner_q ? s1_tlast  : s0_tlast;
  assign selRReady = owner_q ? r1_tready : r0_tready;
  assign isInLast  = (inCnt_q == IN_LAST);
  assign isOutLast = (outCnt_q == OUT_LAST);
  assign inHs      = (state_q == FEED) && selSValid && e_ss_tready;
  assign outHs     = (state_q == DRAIN) && e_sm_tvalid && selRReady;

  // Zero-latency stream muxing; only the current owner ever sees a ready or a result.
  always_comb begin
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    e_ss_tvalid = 1'b0;
    e_ss_tdata  = '0;
    e_ss_tlast  = 1'b0;
    e_sm_tready = 1'b0;
    r0_tvalid   = 1'b0;
    r0_tdata    = '0;
    r0_tlast    = 1'b0;
    r1_tvalid   = 1'b0;
    r1_tdata    = '0;
    r1_tlast    = 1'b0;
    if (state_q == FEED) begin
      e_ss_tvalid = selSValid;
      e_ss_tdata  = selSData;
      e_ss_tlast  = isInLast;
      if (owner_q) s1_tready = e_ss_tready;
      else         s0_tready = e_ss_tready;
    end
    if (state_q == DRAIN) begin
      e_sm_tready = selRReady;
      if (owner_q) begin
        r1_tvalid = e_sm_tvalid;
        r1_tdata  = e_sm_tdata;
        r1_tlast  = isOutLast;
      end else begin
        r0_tvalid = e_sm_tvalid;
        r0_tdata  = e_sm_tdata;
        r0_tlast  = isOutLast;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    inCnt_d     = inCnt_q;
    outCnt_d    = outCnt_q;
    rstCnt_d    = rstCnt_q;
    errTlast_d  = errTlast_q;
    jobCnt0_d   = jobCnt0_q;
    jobCnt1_d   = jobCnt1_q;
    engRstN_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          state_d = FEED;
          owner_d = (s0_tvalid && s1_tvalid) ? ~lastGrant_q : s1_tvalid;
        end
      end
      FEED: begin
        if (inHs) begin
          if (selSLast != isInLast) errTlast_d = 1'b1;
          if (isInLast) begin
            inCnt_d = '0;
            state_d = DRAIN;
          end else begin
            inCnt_d = inCnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (outHs) begin
          if (isOutLast) begin
            outCnt_d    = '0;
            rstCnt_d    = '0;
            state_d     = ERST;
            engRstN_d   = 1'b0;
            lastGrant_d = owner_q;
            if (owner_q) jobCnt1_d = jobCnt1_q + 16'd1;
            else         jobCnt0_d = jobCnt0_q + 16'd1;
          end else begin
            outCnt_d = outCnt_q + 1'b1;
          end
        end
      end
      ERST: begin
        // Engine reset is registered so it drops on the cycle ERST is entered and rises on leaving.
        engRstN_d = 1'b0;
        if (rstCnt_q == RST_LAST) begin
          rstCnt_d  = '0;
          state_d   = IDLE;
          engRstN_d = 1'b1;
        end else begin
          rstCnt_d = rstCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      inCnt_q     <= '0;
      outCnt_q    <= '0;
      rstCnt_q    <= '0;
      errTlast_q  <= 1'b0;
      jobCnt0_q   <= '0;
      jobCnt1_q   <= '0;
      engRstN_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      inCnt_q     <= inCnt_d;
      outCnt_q    <= outCnt_d;
      rstCnt_q    <= rstCnt_d;
      errTlast_q  <= errTlast_d;
      jobCnt0_q   <= jobCnt0_d;
      jobCnt1_q   <= jobCnt1_d;
      engRstN_q   <= engRstN_d;
    end
  end

  assign eng_rst_n = engRstN_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign err_tlast = errTlast_q;
  assign job_cnt0  = jobCnt0_q;
  assign job_cnt1  = jobCnt1_q;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Bench for mm_job_arbiter: two random requesters, a behavioural 4x4 engine stub,
// and a scoreboard that checks every routed result against a matrix-product model.
module tb_mm_job_arbiter;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b1;
  logic        s0_tvalid, s0_tlast, s1_tvalid, s1_tlast;
  logic [31:0] s0_tdata, s1_tdata;
  logic        s0_tready, s1_tready;
  logic        r0_tvalid, r0_tlast, r1_tvalid, r1_tlast;
  logic [31:0] r0_tdata, r1_tdata;
  logic        r0_tready, r1_tready;
  logic        e_ss_tvalid, e_ss_tlast, e_ss_tready;
  logic [31:0] e_ss_tdata;
  logic        e_sm_tvalid, e_sm_tready;
  logic [31:0] e_sm_tdata;
  logic        eng_rst_n, owner, busy, err_tlast;
  logic [15:0] job_cnt0, job_cnt1;

  int          tests = 0;
  int          fails = 0;
  bit          done = 1'b0;
  bit          stallMode = 1'b0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          grantLog[$];
  int          expCnt0 = 0;
  int          expCnt1 = 0;
  int          modelLast = 1;
  int          ssCnt = 0, rCnt0 = 0, rCnt1 = 0, lowCnt = 0;

  always #5 axis_clk = ~axis_clk;

  mm_job_arbiter dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .r0_tvalid(r0_tvalid), .r0_tdata(r0_tdata), .r0_tlast(r0_tlast), .r0_tready(r0_tready),
    .r1_tvalid(r1_tvalid), .r1_tdata(r1_tdata), .r1_tlast(r1_tlast), .r1_tready(r1_tready),
    .e_ss_tvalid(e_ss_tvalid), .e_ss_tdata(e_ss_tdata), .e_ss_tlast(e_ss_tlast),
    .e_ss_tready(e_ss_tready),
    .e_sm_tvalid(e_sm_tvalid), .e_sm_tdata(e_sm_tdata), .e_sm_tready(e_sm_tready),
    .eng_rst_n(eng_rst_n), .owner(owner), .busy(busy), .err_tlast(err_tlast),
    .job_cnt0(job_cnt0), .job_cnt1(job_cnt1)
  );

  // Engine stub: collects 16 B then 16 A words, then streams C = A x B row-major.
  logic [31:0] engMem [32];
  int          engIn = 0, engOut = 0;
  logic [31:0] engAcc;

  always @(posedge axis_clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      engIn  <= 0;
      engOut <= 0;
    end else begin
      if (e_ss_tvalid && e_ss_tready && engIn < 32) begin
        engMem[engIn] <= e_ss_tdata;
        engIn <= engIn + 1;
      end
      if (e_sm_tvalid && e_sm_tready) engOut <= engOut + 1;
    end
  end

  always_comb begin
    engAcc = '0;
    if (engOut < 16)
      for (int k = 0; k < 4; k++)
        engAcc = engAcc + engMem[16 + (engOut / 4) * 4 + k] * engMem[k * 4 + engOut % 4];
  end

  assign e_sm_tvalid = eng_rst_n && (engIn == 32) && (engOut < 16);
  assign e_sm_tdata  = engAcc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveS(input int req, input logic v, input logic [31:0] d, input logic l);
    if (req == 0) begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
    else          begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
  endtask

  task automatic waitReady(input int req, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge axis_clk);
      if ((req == 0) ? s0_tready : s1_tready) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput($sformatf("s%0d_tready timeout", req), 32'd0, 32'd1);
    @(posedge axis_clk); #1;
  endtask

  task automatic waitIdle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge axis_clk);
      if (exp0.size() == 0 && exp1.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput({tag, " job completion timeout"}, 32'd0, 32'd1);
  endtask

  // One job: random (or identity-B / 1..16-A) matrices, model result pushed before the beats go out.
  task automatic applyStimulus(input int req, input bit ident, input int gapMax,
                               input int badBeat, input int abortAfter);
    logic [31:0] w [32];
    logic [31:0] acc;
    bit ok;
    for (int i = 0; i < 32; i++) begin
      if (ident) w[i] = (i < 16) ? ((i / 4 == i % 4) ? 32'd1 : 32'd0) : 32'(i - 15);
      else       w[i] = $urandom();
    end
    if (abortAfter < 0) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc = '0;
          for (int k = 0; k < 4; k++) acc = acc + w[16 + r * 4 + k] * w[k * 4 + c];
          if (req == 0) exp0.push_back(acc);
          else          exp1.push_back(acc);
        end
    end
    for (int b = 0; b < 32; b++) begin
      if (gapMax > 0) begin
        repeat ($urandom_range(0, gapMax)) begin
          driveS(req, 1'b0, 32'd0, 1'b0);
          @(posedge axis_clk); #1;
        end
      end
      driveS(req, 1'b1, w[b], (b == 31) || (b == badBeat));
      waitReady(req, ok);
      if (!ok) break;
      if (b + 1 == abortAfter) break;
    end
    driveS(req, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic doReset();
    axis_rst_n = 1'b0;
    driveS(0, 1'b0, 32'd0, 1'b0);
    driveS(1, 1'b0, 32'd0, 1'b0);
    exp0.delete();
    exp1.delete();
    expCnt0 = 0;
    expCnt1 = 0;
    modelLast = 1;
    repeat (3) @(posedge axis_clk);
    #1 axis_rst_n = 1'b1;
  endtask

  task automatic noteJob(input int req);
    if (req == 0) expCnt0++;
    else          expCnt1++;
    modelLast = req;
  endtask

  function automatic int modelGrant(input bit v0, input bit v1);
    if (v0 && v1) return (modelLast == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic checkCounts(input string tag);
    checkOutput({tag, " job_cnt0"}, 32'(job_cnt0), 32'(expCnt0 % 65536));
    checkOutput({tag, " job_cnt1"}, 32'(job_cnt1), 32'(expCnt1 % 65536));
  endtask

  initial begin
    int g1, g2, g3, req;
    bit early;
    s0_tvalid = 0; s0_tdata = 0; s0_tlast = 0;
    s1_tvalid = 0; s1_tdata = 0; s1_tlast = 0;
    e_ss_tready = 1; r0_tready = 1; r1_tready = 1;
    #2;
    fork
      begin
        // Reset values, sampled while reset is held.
        axis_rst_n = 1'b0;
        #1;
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst owner", 32'(owner), 32'd0);
        checkOutput("rst eng_rst_n", 32'(eng_rst_n), 32'd0);
        checkOutput("rst s0_tready", 32'(s0_tready), 32'd0);
        checkOutput("rst s1_tready", 32'(s1_tready), 32'd0);
        checkOutput("rst e_ss_tvalid", 32'(e_ss_tvalid), 32'd0);
        checkOutput("rst e_sm_tready", 32'(e_sm_tready), 32'd0);
        checkOutput("rst r0_tvalid", 32'(r0_tvalid), 32'd0);
        checkOutput("rst r1_tvalid", 32'(r1_tvalid), 32'd0);
        checkOutput("rst err_tlast", 32'(err_tlast), 32'd0);
        checkCounts("rst");
        repeat (2) @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        checkOutput("eng_rst_n release", 32'(eng_rst_n), 32'd1);

        // T1: identity B, A = 1..16 on s0.
        grantLog.delete();
        applyStimulus(0, 1'b1, 0, -1, -1);
        waitIdle("T1");
        noteJob(0);
        checkCounts("T1");
        checkOutput("T1 owner", 32'(owner), 32'd0);

        // T2: simultaneous requests from reset, s0 has a second job queued.
        doReset();
        grantLog.delete();
        g1 = modelGrant(1'b1, 1'b1); noteJob(g1);
        g2 = modelGrant(1'b1, 1'b1); noteJob(g2);
        g3 = modelGrant(1'b1, 1'b0); noteJob(g3);
        fork
          begin
            applyStimulus(0, 1'b0, 0, -1, -1);
            applyStimulus(0, 1'b0, 0, -1, -1);
          end
          applyStimulus(1, 1'b0, 0, -1, -1);
        join
        waitIdle("T2");
        checkOutput("T2 grant count", 32'(grantLog.size()), 32'd3);
        if (grantLog.size() >= 3) begin
          checkOutput("T2 grant 1", 32'(grantLog[0]), 32'(g1));
          checkOutput("T2 grant 2", 32'(grantLog[1]), 32'(g2));
          checkOutput("T2 grant 3", 32'(grantLog[2]), 32'(g3));
        end
        checkCounts("T2");

        // T3: random requesters, gaps and stalls on every stream.
        stallMode = 1'b1;
        for (int j = 0; j < 6; j++) begin
          req = int'($urandom_range(0, 1));
          applyStimulus(req, 1'b0, 3, -1, -1);
          waitIdle("T3");
          noteJob(req);
          checkOutput("T3 owner", 32'(owner), 32'(req));
          checkCounts("T3");
        end
        stallMode = 1'b0;
        checkOutput("T3 err_tlast clean", 32'(err_tlast), 32'd0);

        // T4: early tlast on beat 20 from s1.
        applyStimulus(1, 1'b0, 1, 19, -1);
        waitIdle("T4");
        noteJob(1);
        checkOutput("T4 err_tlast", 32'(err_tlast), 32'd1);
        checkCounts("T4");

        // T5: s1 requests while the s0 job drains.
        stallMode = 1'b1;
        grantLog.delete();
        applyStimulus(0, 1'b0, 0, -1, -1);
        driveS(1, 1'b1, 32'hdead_beef, 1'b0);
        early = 1'b0;
        for (int i = 0; i < 4000; i++) begin
          @(negedge axis_clk);
          if (!busy) break;
          if (s1_tready) early = 1'b1;
        end
        checkOutput("T5 s1_tready during s0 job", 32'(early), 32'd0);
        applyStimulus(1, 1'b0, 0, -1, -1);
        waitIdle("T5");
        noteJob(0);
        noteJob(1);
        stallMode = 1'b0;
        checkOutput("T5 grant count", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() >= 2) checkOutput("T5 second grant", 32'(grantLog[1]), 32'd1);
        checkOutput("T5 err_tlast sticky", 32'(err_tlast), 32'd1);
        checkCounts("T5");

        // T6: reset after beat 10 of an s0 job, then a clean s1 job.
        applyStimulus(0, 1'b0, 0, -1, 10);
        axis_rst_n = 1'b0;
        #1;
        checkOutput("T6 busy", 32'(busy), 32'd0);
        checkOutput("T6 eng_rst_n", 32'(eng_rst_n), 32'd0);
        checkOutput("T6 s0_tready", 32'(s0_tready), 32'd0);
        checkOutput("T6 e_ss_tvalid", 32'(e_ss_tvalid), 32'd0);
        checkOutput("T6 job_cnt0", 32'(job_cnt0), 32'd0);
        doReset();
        applyStimulus(1, 1'b0, 2, -1, -1);
        waitIdle("T6");
        noteJob(1);
        checkCounts("T6");
        checkOutput("T6 owner", 32'(owner), 32'd1);
        checkOutput("T6 err_tlast cleared", 32'(err_tlast), 32'd0);
        done = 1'b1;
      end

      begin
        while (!done) begin
          @(posedge axis_clk); #1;
          e_ss_tready = stallMode ? ($urandom_range(0, 3) != 0) : 1'b1;
          r0_tready   = stallMode ? ($urandom_range(0, 2) != 0) : 1'b1;
          r1_tready   = stallMode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
      end

      // Scoreboard monitor: pops a model result for every result handshake it sees.
      begin
        while (!done) begin
          @(negedge axis_clk);
          if (!axis_rst_n) begin
            ssCnt = 0; rCnt0 = 0; rCnt1 = 0; lowCnt = 0;
            continue;
          end
          if (e_ss_tvalid && e_ss_tready) begin
            if (ssCnt == 0) grantLog.push_back(int'(s1_tready));
            checkOutput($sformatf("e_ss_tlast beat %0d", ssCnt + 1), 32'(e_ss_tlast),
                        32'(ssCnt == 31));
            ssCnt = (ssCnt == 31) ? 0 : ssCnt + 1;
          end
          if (r0_tvalid) begin
            if (exp0.size() == 0) checkOutput("r0_tvalid unexpected", 32'd1, 32'd0);
            else if (r0_tready) begin
              checkOutput($sformatf("r0 data %0d", rCnt0), r0_tdata, exp0.pop_front());
              checkOutput($sformatf("r0 tlast %0d", rCnt0), 32'(r0_tlast), 32'(rCnt0 == 15));
              rCnt0 = (rCnt0 == 15) ? 0 : rCnt0 + 1;
            end
          end
          if (r1_tvalid) begin
            if (exp1.size() == 0) checkOutput("r1_tvalid unexpected", 32'd1, 32'd0);
            else if (r1_tready) begin
              checkOutput($sformatf("r1 data %0d", rCnt1), r1_tdata, exp1.pop_front());
              checkOutput($sformatf("r1 tlast %0d", rCnt1), 32'(r1_tlast), 32'(rCnt1 == 15));
              rCnt1 = (rCnt1 == 15) ? 0 : rCnt1 + 1;
            end
          end
          if (busy && !eng_rst_n) lowCnt++;
          else if (lowCnt > 0) begin
            checkOutput("eng_rst_n low cycles", 32'(lowCnt), 32'd2);
            lowCnt = 0;
          end
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
